// File: rtl/pwr_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module : pwr_seq_ctrl
// Power-down / power-up sequencer for the switchable memory-controller domain.
// Optional feature macro: PSC_ACK_TIMEOUT_EN (power-switch ack timeout -> ERR)
// Rev    : 1.0  initial release
// ============================================================================

module pwr_seq_ctrl #(
    parameter int STEP_CYC = 2,
    parameter int SAVE_CYC = 1,
    parameter int ACK_TMO  = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic req_off,
    input  logic req_on,
    input  logic sram_off,
    input  logic mc_pwr_ack,
    output logic mc_clk_gate,
    output logic mc_iso,
    output logic mc_save,
    output logic mc_restore,
    output logic mc_pwr,
    output logic sram_pwr,
    output logic busy,
    output logic is_off,
    output logic err
);

    localparam int c_max_ss  = (STEP_CYC > SAVE_CYC) ? STEP_CYC : SAVE_CYC;
    localparam int c_max_all = (c_max_ss > ACK_TMO) ? c_max_ss : ACK_TMO;
    localparam int c_cnt_w   = $clog2(c_max_all + 1);

    // Dwell loads are parameter-1 so that a state lasts exactly the parameter
    localparam logic [c_cnt_w-1:0] c_step_ld = c_cnt_w'(STEP_CYC - 1);
    localparam logic [c_cnt_w-1:0] c_save_ld = c_cnt_w'(SAVE_CYC - 1);
    localparam logic [c_cnt_w-1:0] c_cnt_one = c_cnt_w'(1);
`ifdef PSC_ACK_TIMEOUT_EN
    localparam logic [c_cnt_w-1:0] c_ack_ld  = c_cnt_w'(ACK_TMO - 1);
`endif

    localparam logic [3:0] c_st_on      = 4'd0;
    localparam logic [3:0] c_st_clk_off = 4'd1;
    localparam logic [3:0] c_st_iso_on  = 4'd2;
    localparam logic [3:0] c_st_save    = 4'd3;
    localparam logic [3:0] c_st_pwr_dn  = 4'd4;
    localparam logic [3:0] c_st_off     = 4'd5;
    localparam logic [3:0] c_st_pwr_up  = 4'd6;
    localparam logic [3:0] c_st_restore = 4'd7;
    localparam logic [3:0] c_st_iso_off = 4'd8;
    localparam logic [3:0] c_st_clk_on  = 4'd9;
`ifdef PSC_ACK_TIMEOUT_EN
    localparam logic [3:0] c_st_err     = 4'd10;
`endif

    logic [3:0]         r_state;
    logic [c_cnt_w-1:0] r_cnt;
    logic               r_sram_lat;
    logic               r_clk_gate;
    logic               r_iso;
    logic               r_save;
    logic               r_restore;
    logic               r_pwr;
    logic               r_sram_pwr;
    logic               r_busy;
    logic               r_is_off;

    logic [3:0]         w_state_nxt;
    logic [c_cnt_w-1:0] w_cnt_nxt;
    logic [c_cnt_w-1:0] w_cnt_dec;
    logic               w_cnt_zero;
    logic               w_sram_lat_nxt;
    logic               w_clk_gate_nxt;
    logic               w_iso_nxt;
    logic               w_save_nxt;
    logic               w_restore_nxt;
    logic               w_pwr_nxt;
    logic               w_sram_pwr_nxt;

    assign w_cnt_dec  = r_cnt - c_cnt_one;
    assign w_cnt_zero = (r_cnt == '0);

    // Next state and next output values; outputs hold unless a transition
    // changes them, which also freezes everything in ERR.
    always_comb begin
        w_state_nxt    = r_state;
        w_cnt_nxt      = r_cnt;
        w_sram_lat_nxt = r_sram_lat;
        w_clk_gate_nxt = r_clk_gate;
        w_iso_nxt      = r_iso;
        w_save_nxt     = r_save;
        w_restore_nxt  = r_restore;
        w_pwr_nxt      = r_pwr;
        w_sram_pwr_nxt = r_sram_pwr;

        case (r_state)
            c_st_on: begin
                if (req_off) begin
                    w_state_nxt    = c_st_clk_off;
                    w_cnt_nxt      = c_step_ld;
                    w_clk_gate_nxt = 1'b0;
                    w_sram_lat_nxt = sram_off;
                end
            end
            c_st_clk_off: begin
                if (w_cnt_zero) begin
                    w_state_nxt = c_st_iso_on;
                    w_cnt_nxt   = c_step_ld;
                    w_iso_nxt   = 1'b1;
                end else begin
                    w_cnt_nxt = w_cnt_dec;
                end
            end
            c_st_iso_on: begin
                if (w_cnt_zero) begin
                    w_state_nxt = c_st_save;
                    w_cnt_nxt   = c_save_ld;
                    w_save_nxt  = 1'b1;
                end else begin
                    w_cnt_nxt = w_cnt_dec;
                end
            end
            c_st_save: begin
                if (w_cnt_zero) begin
                    w_state_nxt    = c_st_pwr_dn;
                    w_save_nxt     = 1'b0;
                    w_pwr_nxt      = 1'b0;
                    w_sram_pwr_nxt = r_sram_lat;
`ifdef PSC_ACK_TIMEOUT_EN
                    w_cnt_nxt      = c_ack_ld;
`endif
                end else begin
                    w_cnt_nxt = w_cnt_dec;
                end
            end
            c_st_pwr_dn: begin
                if (!mc_pwr_ack) begin
                    w_state_nxt = c_st_off;
                end
`ifdef PSC_ACK_TIMEOUT_EN
                else if (w_cnt_zero) begin
                    w_state_nxt = c_st_err;
                end else begin
                    w_cnt_nxt = w_cnt_dec;
                end
`endif
            end
            c_st_off: begin
                if (req_on) begin
                    w_state_nxt    = c_st_pwr_up;
                    w_pwr_nxt      = 1'b1;
                    w_sram_pwr_nxt = 1'b0;
`ifdef PSC_ACK_TIMEOUT_EN
                    w_cnt_nxt      = c_ack_ld;
`endif
                end
            end
            c_st_pwr_up: begin
                if (mc_pwr_ack) begin
                    w_state_nxt   = c_st_restore;
                    w_cnt_nxt     = c_save_ld;
                    w_restore_nxt = 1'b1;
                end
`ifdef PSC_ACK_TIMEOUT_EN
                else if (w_cnt_zero) begin
                    w_state_nxt = c_st_err;
                end else begin
                    w_cnt_nxt = w_cnt_dec;
                end
`endif
            end
            c_st_restore: begin
                if (w_cnt_zero) begin
                    w_state_nxt   = c_st_iso_off;
                    w_cnt_nxt     = c_step_ld;
                    w_restore_nxt = 1'b0;
                    w_iso_nxt     = 1'b0;
                end else begin
                    w_cnt_nxt = w_cnt_dec;
                end
            end
            c_st_iso_off: begin
                if (w_cnt_zero) begin
                    w_state_nxt    = c_st_clk_on;
                    w_cnt_nxt      = c_step_ld;
                    w_clk_gate_nxt = 1'b1;
                end else begin
                    w_cnt_nxt = w_cnt_dec;
                end
            end
            c_st_clk_on: begin
                if (w_cnt_zero) begin
                    w_state_nxt = c_st_on;
                end else begin
                    w_cnt_nxt = w_cnt_dec;
                end
            end
`ifdef PSC_ACK_TIMEOUT_EN
            c_st_err: begin
                w_state_nxt = c_st_err;
            end
`endif
            default: begin
                w_state_nxt    = c_st_on;
                w_cnt_nxt      = '0;
                w_clk_gate_nxt = 1'b1;
                w_iso_nxt      = 1'b0;
                w_save_nxt     = 1'b0;
                w_restore_nxt  = 1'b0;
                w_pwr_nxt      = 1'b1;
                w_sram_pwr_nxt = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= c_st_on;
            r_cnt      <= '0;
            r_sram_lat <= 1'b0;
            r_clk_gate <= 1'b1;
            r_iso      <= 1'b0;
            r_save     <= 1'b0;
            r_restore  <= 1'b0;
            r_pwr      <= 1'b1;
            r_sram_pwr <= 1'b0;
            r_busy     <= 1'b0;
            r_is_off   <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_sram_lat <= w_sram_lat_nxt;
            r_clk_gate <= w_clk_gate_nxt;
            r_iso      <= w_iso_nxt;
            r_save     <= w_save_nxt;
            r_restore  <= w_restore_nxt;
            r_pwr      <= w_pwr_nxt;
            r_sram_pwr <= w_sram_pwr_nxt;
            r_busy     <= (w_state_nxt != c_st_on) && (w_state_nxt != c_st_off);
            r_is_off   <= (w_state_nxt == c_st_off);
        end
    end

`ifdef PSC_ACK_TIMEOUT_EN
    logic r_err;

    // ERR is terminal until reset, so the flag is sticky by construction
    always_ff @(posedge clk) begin
        if (rst) begin
            r_err <= 1'b0;
        end else begin
            r_err <= (w_state_nxt == c_st_err);
        end
    end

    assign err = r_err;
`else
    assign err = 1'b0;
`endif

    assign mc_clk_gate = r_clk_gate;
    assign mc_iso      = r_iso;
    assign mc_save     = r_save;
    assign mc_restore  = r_restore;
    assign mc_pwr      = r_pwr;
    assign sram_pwr    = r_sram_pwr;
    assign busy        = r_busy;
    assign is_off      = r_is_off;

endmodule

`default_nettype wire

// File: tb/tb_pwr_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module : tb_pwr_seq_ctrl
// Directed self-checking bench for pwr_seq_ctrl (default parameters).
// Rev    : 1.0  initial release
// ============================================================================

module tb_pwr_seq_ctrl;

    logic clk;
    logic rst;
    logic req_off;
    logic req_on;
    logic sram_off;
    logic mc_pwr_ack;
    logic mc_clk_gate;
    logic mc_iso;
    logic mc_save;
    logic mc_restore;
    logic mc_pwr;
    logic sram_pwr;
    logic busy;
    logic is_off;
    logic err;

    int n_cmp;
    int n_fail;

    // {clk_gate, iso, save, restore, pwr, sram_pwr, busy, is_off, err}
    logic [8:0] obs_vec;
    assign obs_vec = {mc_clk_gate, mc_iso, mc_save, mc_restore, mc_pwr,
                      sram_pwr, busy, is_off, err};

    localparam logic [8:0] V_RST     = 9'b1_0_0_0_1_0_0_0_0;
    localparam logic [8:0] V_CLK_OFF = 9'b0_0_0_0_1_0_1_0_0;
    localparam logic [8:0] V_ISO_ON  = 9'b0_1_0_0_1_0_1_0_0;
    localparam logic [8:0] V_SAVE    = 9'b0_1_1_0_1_0_1_0_0;
    localparam logic [8:0] V_PWR_DN  = 9'b0_1_0_0_0_0_1_0_0;
    localparam logic [8:0] V_PDN_SR  = 9'b0_1_0_0_0_1_1_0_0;
    localparam logic [8:0] V_OFF     = 9'b0_1_0_0_0_0_0_1_0;
    localparam logic [8:0] V_OFF_SR  = 9'b0_1_0_0_0_1_0_1_0;
    localparam logic [8:0] V_PWR_UP  = 9'b0_1_0_0_1_0_1_0_0;
    localparam logic [8:0] V_RESTORE = 9'b0_1_0_1_1_0_1_0_0;
    localparam logic [8:0] V_ISO_OFF = 9'b0_0_0_0_1_0_1_0_0;
    localparam logic [8:0] V_CLK_ON  = 9'b1_0_0_0_1_0_1_0_0;
    localparam logic [8:0] V_ERR     = 9'b0_1_0_0_0_0_1_0_1;

    // Power-down, req_off driven after edge N: entry k is the value after edge N+k
    logic [8:0] exp_dn [1:8] = '{V_CLK_OFF, V_CLK_OFF, V_ISO_ON, V_ISO_ON,
                                 V_SAVE, V_PWR_DN, V_PWR_DN, V_OFF};
    // Power-up, req_on after edge M, ack first sampled high at edge M+6
    logic [8:0] exp_up [1:11] = '{V_PWR_UP, V_PWR_UP, V_PWR_UP, V_PWR_UP,
                                  V_PWR_UP, V_RESTORE, V_ISO_OFF, V_ISO_OFF,
                                  V_CLK_ON, V_CLK_ON, V_RST};
    // Down with SRAM off then straight back up
    logic [8:0] exp_sr [1:15] = '{V_CLK_OFF, V_CLK_OFF, V_ISO_ON, V_ISO_ON,
                                  V_SAVE, V_PDN_SR, V_PDN_SR, V_OFF_SR,
                                  V_PWR_UP, V_RESTORE, V_ISO_OFF, V_ISO_OFF,
                                  V_CLK_ON, V_CLK_ON, V_RST};

    pwr_seq_ctrl #(
        .STEP_CYC (2),
        .SAVE_CYC (1),
        .ACK_TMO  (16)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req_off     (req_off),
        .req_on      (req_on),
        .sram_off    (sram_off),
        .mc_pwr_ack  (mc_pwr_ack),
        .mc_clk_gate (mc_clk_gate),
        .mc_iso      (mc_iso),
        .mc_save     (mc_save),
        .mc_restore  (mc_restore),
        .mc_pwr      (mc_pwr),
        .sram_pwr    (sram_pwr),
        .busy        (busy),
        .is_off      (is_off),
        .err         (err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [8:0] obs, input logic [8:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    // Safety invariants checked on every falling edge
    always @(negedge clk) begin
        n_cmp++;
        assert (!(mc_save && mc_restore)) else begin
            n_fail++;
            $error("FAIL inv_save_restore: observed save=%b restore=%b expected not both 1",
                   mc_save, mc_restore);
        end
        n_cmp++;
        assert (mc_pwr || mc_iso) else begin
            n_fail++;
            $error("FAIL inv_pwr_iso: observed pwr=%b iso=%b expected iso=1 when pwr=0",
                   mc_pwr, mc_iso);
        end
    end

    initial begin
        n_cmp      = 0;
        n_fail     = 0;
        rst        = 1'b1;
        req_off    = 1'b0;
        req_on     = 1'b0;
        sram_off   = 1'b0;
        mc_pwr_ack = 1'b1;

        // Reset held for three edges
        repeat (3) step();
        chk("reset_vals", obs_vec, V_RST);
        rst = 1'b0;
        step();
        chk("idle_on", obs_vec, V_RST);

        // Plain power-down, ack drops after edge N+7
        req_off = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            step();
            chk($sformatf("dn[%0d]", i), obs_vec, exp_dn[i]);
            if (i == 1) req_off = 1'b0;
            if (i == 7) mc_pwr_ack = 1'b0;
        end
        step();
        chk("off_hold", obs_vec, V_OFF);

        // Power-up; req_off held across the sequence must be ignored
        req_on = 1'b1;
        for (int i = 1; i <= 11; i++) begin
            step();
            chk($sformatf("up[%0d]", i), obs_vec, exp_up[i]);
            if (i == 1) begin
                req_on  = 1'b0;
                req_off = 1'b1;
            end
            if (i == 5) mc_pwr_ack = 1'b1;
            if (i == 9) req_off = 1'b0;
        end

        // SRAM power-down, both requests high in ON and in OFF
        req_off  = 1'b1;
        req_on   = 1'b1;
        sram_off = 1'b1;
        for (int i = 1; i <= 15; i++) begin
            step();
            chk($sformatf("sr[%0d]", i), obs_vec, exp_sr[i]);
            if (i == 1) begin
                req_off  = 1'b0;
                sram_off = 1'b0;
            end
            if (i == 7) begin
                mc_pwr_ack = 1'b0;
                req_on     = 1'b0;
            end
            if (i == 8) begin
                req_on  = 1'b1;
                req_off = 1'b1;
            end
            if (i == 9) begin
                req_on     = 1'b0;
                req_off    = 1'b0;
                mc_pwr_ack = 1'b1;
            end
        end

        // Reset while in SAVE
        req_off = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            step();
            if (i == 1) req_off = 1'b0;
        end
        chk("in_save", obs_vec, V_SAVE);
        rst = 1'b1;
        step();
        chk("rst_from_save", obs_vec, V_RST);
        rst = 1'b0;
        step();
        chk("on_after_rst", obs_vec, V_RST);

`ifdef PSC_ACK_TIMEOUT_EN
        // Ack never drops: PWR_DN entered at R+6, ERR after 16 cycles at R+22
        req_off = 1'b1;
        for (int i = 1; i <= 22; i++) begin
            step();
            if (i == 1) req_off = 1'b0;
            if (i == 21) chk("tmo_pwr_dn", obs_vec, V_PWR_DN);
        end
        chk("tmo_err", obs_vec, V_ERR);
        req_on     = 1'b1;
        mc_pwr_ack = 1'b0;
        repeat (3) step();
        chk("err_sticky", obs_vec, V_ERR);
        req_on = 1'b0;
        rst    = 1'b1;
        step();
        chk("rst_from_err", obs_vec, V_RST);
        rst = 1'b0;
`endif

        step();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
